// File: rtl/pwm_pkg.sv
// pwm_pkg: shared state encodings for PWM-side control blocks.
package pwm_pkg;
    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_RAMP_UP   = 3'd1;
    localparam logic [2:0] S_HOLD_HIGH = 3'd2;
    localparam logic [2:0] S_RAMP_DOWN = 3'd3;
    localparam logic [2:0] S_HOLD_LOW  = 3'd4;
    typedef enum logic [2:0] {
        IDLE      = S_IDLE,
        RAMP_UP   = S_RAMP_UP,
        HOLD_HIGH = S_HOLD_HIGH,
        RAMP_DOWN = S_RAMP_DOWN,
        HOLD_LOW  = S_HOLD_LOW
    } fade_state_t;
endpackage

// File: rtl/pwm_boundary_det.sv
// pwm_boundary_det: flags the last cycle of a PWM period (counter at max_value while enabled).
module pwm_boundary_det #(
    parameter int bit_width = 3
) (
    input  logic                 enable,
    input  logic [bit_width-1:0] pwm_counter,
    input  logic [bit_width-1:0] max_value,
    output logic                 bnd
);
    assign bnd = enable && (pwm_counter == max_value);
endmodule

// File: rtl/pwm_fade_ctrl.sv
// pwm_fade_ctrl: trapezoidal duty sequencer updating duty only at PWM period boundaries.
// Define PWM_FADE_LOOP_EN to add the loop input for continuous breathing.
import pwm_pkg::*;
module pwm_fade_ctrl #(
    parameter int bit_width = 3,
    parameter int HOLD_W    = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic                 start,
    input  logic                 stop,
`ifdef PWM_FADE_LOOP_EN
    input  logic                 loop,
`endif
    input  logic [bit_width-1:0] pwm_counter,
    input  logic [bit_width-1:0] max_value,
    input  logic [bit_width-1:0] peak,
    input  logic [bit_width-1:0] floor,
    input  logic [bit_width-1:0] step,
    input  logic [HOLD_W-1:0]    hold_periods,
    output logic [bit_width-1:0] duty,
    output logic                 busy,
    output logic                 done
);
    fade_state_t          state_q, state_d;
    logic [bit_width-1:0] duty_d, pk_s, fl_s, st_s, step_eff;
    logic [HOLD_W-1:0]    hold_q, hold_d, hp_s;
    logic [bit_width:0]   up_sum, dn_lim;
    logic                 bnd, load, done_d;

    pwm_boundary_det #(.bit_width(bit_width)) u_bnd (
        .enable      (enable),
        .pwm_counter (pwm_counter),
        .max_value   (max_value),
        .bnd         (bnd)
    );

    // Sums carry one extra bit so the saturation tests cannot wrap.
    assign step_eff = (st_s == '0) ? bit_width'(1) : st_s;
    assign up_sum   = {1'b0, duty} + {1'b0, step_eff};
    assign dn_lim   = {1'b0, fl_s} + {1'b0, step_eff};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        duty_d  = duty;
        hold_d  = hold_q;
        done_d  = 1'b0;
        load    = 1'b0;
        if (enable && stop) begin
            state_d = IDLE;
            duty_d  = '0;
        end else if (state_q == IDLE) begin
            if (enable && start && peak > floor) begin
                load    = 1'b1;
                duty_d  = floor;
                state_d = RAMP_UP;
            end
        end else if (bnd) begin
            case (state_q)
                RAMP_UP: begin
                    if (up_sum >= {1'b0, pk_s}) begin
                        duty_d  = pk_s;
                        hold_d  = hp_s;
                        state_d = HOLD_HIGH;
                    end else duty_d = up_sum[bit_width-1:0];
                end
                HOLD_HIGH: begin
                    if (hold_q == '0) state_d = RAMP_DOWN;
                    else              hold_d  = hold_q - 1'b1;
                end
                RAMP_DOWN: begin
                    if ({1'b0, duty} <= dn_lim) begin
                        duty_d  = fl_s;
                        hold_d  = hp_s;
                        state_d = HOLD_LOW;
                    end else duty_d = duty - step_eff;
                end
                HOLD_LOW: begin
                    if (hold_q == '0) begin
`ifdef PWM_FADE_LOOP_EN
                        state_d = loop ? RAMP_UP : IDLE;
                        done_d  = !loop;
`else
                        state_d = IDLE;
                        done_d  = 1'b1;
`endif
                    end else hold_d = hold_q - 1'b1;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign busy = (state_q != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            duty   <= '0;
            hold_q <= '0;
            done   <= 1'b0;
            pk_s   <= '0;
            fl_s   <= '0;
            st_s   <= '0;
            hp_s   <= '0;
        end else begin
            duty   <= duty_d;
            hold_q <= hold_d;
            done   <= done_d;
            if (load) begin
                pk_s <= peak;
                fl_s <= floor;
                st_s <= step;
                hp_s <= hold_periods;
            end
        end
    end
endmodule

// File: tb/tb_pwm_fade_ctrl.sv
// tb_pwm_fade_ctrl: directed checks of the fade sequencer with hand-computed duty profiles.
module tb_pwm_fade_ctrl;
    localparam int BW = 8;
    localparam int HW = 8;

    logic          clk = 1'b0;
    logic          rst_n, enable, start, stop;
    logic          loop;
    logic [BW-1:0] pwm_counter, max_value, peak, floor, step;
    logic [HW-1:0] hold_periods;
    logic [BW-1:0] duty;
    logic          busy, done;
    int            n_cmp = 0;
    int            n_err = 0;

    pwm_fade_ctrl #(.bit_width(BW), .HOLD_W(HW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .start        (start),
        .stop         (stop),
`ifdef PWM_FADE_LOOP_EN
        .loop         (loop),
`endif
        .pwm_counter  (pwm_counter),
        .max_value    (max_value),
        .peak         (peak),
        .floor        (floor),
        .step         (step),
        .hold_periods (hold_periods),
        .duty         (duty),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic run_period;
        for (int i = 0; i <= int'(max_value); i++) begin
            pwm_counter = BW'(i);
            tick();
        end
        pwm_counter = '0;
    endtask

    task automatic do_start(input int pk, input int fl, input int st, input int hp);
        peak = BW'(pk);
        floor = BW'(fl);
        step = BW'(st);
        hold_periods = HW'(hp);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) tick();
        n_cmp += 3;
        if (duty !== 8'd0) begin n_err++; $display("FAIL reset_duty: got %0d want 0", duty); end
        if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
        if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", done); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic_fade;
        int exp_d[8] = '{3, 6, 8, 8, 5, 2, 0, 0};
        do_start(8, 0, 3, 0);
        n_cmp += 2;
        if (busy !== 1'b1) begin n_err++; $display("FAIL basic_start_busy: got %b want 1", busy); end
        if (duty !== 8'd0) begin n_err++; $display("FAIL basic_start_duty: got %0d want 0", duty); end
        do_start(9, 1, 1, 0);
        n_cmp++;
        if (duty !== 8'd0) begin n_err++; $display("FAIL basic_restart_ignored: got %0d want 0", duty); end
        for (int k = 0; k < 8; k++) begin
            run_period();
            n_cmp += 3;
            if (duty !== BW'(exp_d[k])) begin n_err++; $display("FAIL basic_duty[%0d]: got %0d want %0d", k, duty, exp_d[k]); end
            if (busy !== (k != 7)) begin n_err++; $display("FAIL basic_busy[%0d]: got %b want %b", k, busy, k != 7); end
            if (done !== (k == 7)) begin n_err++; $display("FAIL basic_done[%0d]: got %b want %b", k, done, k == 7); end
        end
        tick();
        n_cmp++;
        if (done !== 1'b0) begin n_err++; $display("FAIL basic_done_pulse_width: got %b want 0", done); end
    endtask

    task automatic test_step_zero;
        int exp_d[8] = '{3, 4, 4, 4, 3, 2, 2, 2};
        do_start(4, 2, 0, 1);
        n_cmp++;
        if (duty !== 8'd2) begin n_err++; $display("FAIL step0_start_duty: got %0d want 2", duty); end
        for (int k = 0; k < 8; k++) begin
            run_period();
            n_cmp += 2;
            if (duty !== BW'(exp_d[k])) begin n_err++; $display("FAIL step0_duty[%0d]: got %0d want %0d", k, duty, exp_d[k]); end
            if (done !== (k == 7)) begin n_err++; $display("FAIL step0_done[%0d]: got %b want %b", k, done, k == 7); end
        end
        n_cmp++;
        if (busy !== 1'b0) begin n_err++; $display("FAIL step0_end_busy: got %b want 0", busy); end
        tick();
    endtask

    task automatic test_equal_peak_floor;
        do_start(5, 5, 1, 0);
        n_cmp += 2;
        if (busy !== 1'b0) begin n_err++; $display("FAIL ignore_busy: got %b want 0", busy); end
        if (duty !== 8'd2) begin n_err++; $display("FAIL ignore_duty: got %0d want 2", duty); end
        run_period();
        n_cmp++;
        if (busy !== 1'b0) begin n_err++; $display("FAIL ignore_busy_later: got %b want 0", busy); end
    endtask

    task automatic test_stop;
        do_start(8, 0, 3, 0);
        repeat (5) run_period();
        n_cmp++;
        if (duty !== 8'd5) begin n_err++; $display("FAIL stop_pre_duty: got %0d want 5", duty); end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        n_cmp += 3;
        if (duty !== 8'd0) begin n_err++; $display("FAIL stop_duty: got %0d want 0", duty); end
        if (busy !== 1'b0) begin n_err++; $display("FAIL stop_busy: got %b want 0", busy); end
        if (done !== 1'b0) begin n_err++; $display("FAIL stop_done: got %b want 0", done); end
        tick();
        n_cmp++;
        if (done !== 1'b0) begin n_err++; $display("FAIL stop_done_late: got %b want 0", done); end
    endtask

    task automatic test_enable_freeze;
        do_start(8, 0, 3, 0);
        run_period();
        enable = 1'b0;
        for (int i = 0; i < 20; i++) begin
            pwm_counter = BW'(i % 10);
            tick();
        end
        pwm_counter = '0;
        n_cmp += 2;
        if (duty !== 8'd3) begin n_err++; $display("FAIL freeze_duty: got %0d want 3", duty); end
        if (busy !== 1'b1) begin n_err++; $display("FAIL freeze_busy: got %b want 1", busy); end
        enable = 1'b1;
        run_period();
        n_cmp++;
        if (duty !== 8'd6) begin n_err++; $display("FAIL freeze_resume_duty: got %0d want 6", duty); end
        stop = 1'b1;
        tick();
        stop = 1'b0;
    endtask

    task automatic test_async_reset;
        do_start(8, 0, 3, 2);
        repeat (4) run_period();
        n_cmp += 2;
        if (duty !== 8'd8) begin n_err++; $display("FAIL areset_pre_duty: got %0d want 8", duty); end
        if (busy !== 1'b1) begin n_err++; $display("FAIL areset_pre_busy: got %b want 1", busy); end
        rst_n = 1'b0;
        #2;
        n_cmp += 3;
        if (duty !== 8'd0) begin n_err++; $display("FAIL areset_duty: got %0d want 0", duty); end
        if (busy !== 1'b0) begin n_err++; $display("FAIL areset_busy: got %b want 0", busy); end
        if (done !== 1'b0) begin n_err++; $display("FAIL areset_done: got %b want 0", done); end
        #1;
        rst_n = 1'b1;
        tick();
        run_period();
        n_cmp++;
        if (busy !== 1'b0) begin n_err++; $display("FAIL areset_stays_idle: got %b want 0", busy); end
    endtask

`ifdef PWM_FADE_LOOP_EN
    task automatic test_loop;
        int exp_d[6] = '{3, 4, 4, 3, 2, 2};
        loop = 1'b1;
        do_start(4, 2, 1, 0);
        for (int k = 0; k < 6; k++) begin
            run_period();
            n_cmp += 3;
            if (duty !== BW'(exp_d[k])) begin n_err++; $display("FAIL loop_duty[%0d]: got %0d want %0d", k, duty, exp_d[k]); end
            if (busy !== 1'b1) begin n_err++; $display("FAIL loop_busy[%0d]: got %b want 1", k, busy); end
            if (done !== 1'b0) begin n_err++; $display("FAIL loop_done[%0d]: got %b want 0", k, done); end
        end
        run_period();
        n_cmp++;
        if (duty !== 8'd3) begin n_err++; $display("FAIL loop_reramp_duty: got %0d want 3", duty); end
        loop = 1'b0;
        stop = 1'b1;
        tick();
        stop = 1'b0;
    endtask
`endif

    initial begin
        rst_n = 1'b0;
        enable = 1'b1;
        start = 1'b0;
        stop = 1'b0;
        loop = 1'b0;
        pwm_counter = '0;
        max_value = 8'd9;
        peak = '0;
        floor = '0;
        step = '0;
        hold_periods = '0;
        test_reset();
        test_basic_fade();
        test_step_zero();
        test_equal_peak_floor();
        test_stop();
        test_enable_freeze();
        test_async_reset();
`ifdef PWM_FADE_LOOP_EN
        test_loop();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/pwm_fade_ctrl.md
# pwm_fade_ctrl

Duty-cycle sequencer that sits directly upstream of `pwm_module` and drives its `duty` input with a trapezoidal fade profile: ramp up, hold high, ramp down, hold low. Duty updates happen only at PWM period boundaries, detected from the PWM stage's `counter` output, so no PWM period ever sees a torn duty value. Typical use is LED breathing and soft-start of PWM loads.

## Interface
- `bit_width`, 3: width of duty, max_value, peak, floor, step and the PWM counter; must match the downstream `pwm_module`.
- `HOLD_W`, 8: width of the hold-period count.
- `clk`  in  1  clock, shared with `pwm_module`.
- `rst_n`  in  1  asynchronous, active-low reset.
- `enable`  in  1  same enable that drives `pwm_module`; when low, the block freezes.
- `start`  in  1  single-cycle request to begin a fade sequence.
- `stop`  in  1  abort request; takes priority over `start`.
- `pwm_counter`  in  bit_width  `counter` output of `pwm_module`.
- `max_value`  in  bit_width  same value that drives `pwm_module`.
- `peak`  in  bit_width  duty at the top of the ramp.
- `floor`  in  bit_width  duty at the bottom of the ramp.
- `step`  in  bit_width  duty increment or decrement per period.
- `hold_periods`  in  HOLD_W  number of extra periods spent in each hold state.
- `duty`  out  bit_width  registered duty, wired to `pwm_module.duty`.
- `busy`  out  1  high whenever the state is not IDLE.
- `done`  out  1  one-cycle pulse when a sequence completes.

## Operation
- States: IDLE, RAMP_UP, HOLD_HIGH, RAMP_DOWN, HOLD_LOW.
- Boundary event `bnd` = `enable && pwm_counter == max_value`. All duty and state updates other than start and stop occur only on `bnd`.
- **Starting a sequence**
  - In IDLE, `start` with `peak > floor` latches peak, floor, step and hold_periods into shadow registers.
  - It also sets `duty <= floor` and moves the state to RAMP_UP.
  - `start` with `peak <= floor` is ignored. `start` outside IDLE is ignored.
- **Step rule:** `step == 0` is treated as 1.
- **RAMP_UP** on `bnd`: compute `duty + step` in bit_width+1 bits.
  - If the sum is >= peak: `duty <= peak`, load the hold counter, go to HOLD_HIGH.
  - Otherwise: `duty <= duty + step`.
- **RAMP_DOWN** on `bnd`:
  - If `duty <= floor + step` (bit_width+1 bits): `duty <= floor`, load the hold counter, go to HOLD_LOW.
  - Otherwise: `duty <= duty - step`.
- **HOLD states:** the hold counter is loaded with the latched hold_periods on entry.
  - On each `bnd`: if the counter is 0, leave the state; otherwise decrement.
  - Net effect: the state occupies hold_periods+1 boundaries.
  - HOLD_HIGH exits to RAMP_DOWN.
  - HOLD_LOW exits to IDLE with a `done` pulse (see Configuration for loop mode).
- **Stop:** `stop` in any state moves to IDLE and sets `duty <= 0` on the next edge. No `done` pulse. Stop has priority over `bnd`.
- **Enable low:** no state, duty or counter changes occur.
- **Live inputs:** changes to peak, floor, step or hold_periods mid-sequence have no effect until the next start. A change to max_value takes effect immediately for boundary detection.

## Timing
- Reset values: `duty = 0`, `busy = 0`, `done = 0`, state IDLE, all shadow registers 0.
- `start` → `busy` high and `duty = floor` one cycle later.
- A duty update is registered on the `bnd` edge, which is the same edge on which `pwm_module` wraps its counter to 0. The new duty therefore governs the entire next PWM period.
- `done` is asserted for exactly one cycle, coincident with the edge at which `busy` falls.
- Reset asserted mid-sequence returns all outputs to reset values immediately (asynchronous).

## Configuration
- `PWM_FADE_LOOP_EN` defined:
  - Adds input `loop` (1 bit), sampled on the `bnd` that exits HOLD_LOW.
  - `loop = 1`: go to RAMP_UP with no `done` pulse.
  - `loop = 0`: go to IDLE with a `done` pulse.
- Not defined:
  - No `loop` port.
  - HOLD_LOW always exits to IDLE with a `done` pulse.

## Structure
- Shared package `pwm_pkg`:
  - state enum `fade_state_t`;
  - localparam encodings for the five states.
- One natural sub-module, `pwm_boundary_det`:
  - compares `pwm_counter` against `max_value`, gated by `enable`;
  - outputs `bnd`;
  - reusable by other PWM-side blocks.
- Datapath (saturating add/subtract, hold counter) and the FSM stay in `pwm_fade_ctrl`.

## Test plan
- bit_width=8, max_value=9, floor=0, peak=8, step=3, hold_periods=0, start:
  - duty sequence across boundaries 0, 3, 6, 8, 8, 5, 2, 0, 0;
  - then `done` pulses and `busy` falls.
- step=0, floor=2, peak=4, hold_periods=1:
  - duty 2, 3, 4, held for 2 boundaries, then 3, 2, held for 2 boundaries, then `done`.
- `start` with peak=5, floor=5:
  - state stays IDLE, `busy` stays 0, `duty` unchanged.
- `stop` during RAMP_DOWN:
  - next cycle `duty = 0`, `busy = 0`, no `done`.
- `enable` low for 20 cycles mid-RAMP_UP:
  - `duty` and state are frozen;
  - the ramp resumes at the first `bnd` after `enable` returns high.
- `rst_n` pulsed low mid-HOLD_HIGH with no clock edge:
  - `duty`, `busy` and `done` go to 0 immediately.
- With `PWM_FADE_LOOP_EN` defined and `loop=1`:
  - after HOLD_LOW the state returns to RAMP_UP, `done` stays 0, `busy` stays 1.
